// File: rtl/audio_adc_i2s_receiver.sv
// audio_adc_i2s_receiver
//   Deserializes the codec ADC I2S stream into parallel left/right pairs.
//   BCLK, ADCLRCK and ADCDAT are asynchronous to s_CLK. Each one is synchronized
//   and edge-detected, then the word FSM runs entirely in the s_CLK domain.
// Ports:
//   s_CLK, s_RESET        system clock, async active-high reset
//   s_EN                  receiver enable (low: FSM idles, partial frame dropped)
//   i_BitSCLK, i_ADC_LRCK, i_ADC_Data   codec serial interface (LRCK 0 = left)
//   o_Left, o_Right, o_Valid, i_Ready   stereo pair valid/ready output
//   o_Overrun, i_OverrunClr             sticky pair-dropped flag and its clear
//   o_Busy                FSM is not idle
module audio_adc_i2s_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  s_CLK,
  input  logic                  s_RESET,
  input  logic                  s_EN,
  input  logic                  i_BitSCLK,
  input  logic                  i_ADC_LRCK,
  input  logic                  i_ADC_Data,
  output logic [DATA_WIDTH-1:0] o_Left,
  output logic [DATA_WIDTH-1:0] o_Right,
  input  logic                  i_Ready,
  output logic                  o_Valid,
  output logic                  o_Overrun,
  input  logic                  i_OverrunClr,
  output logic                  o_Busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_WAIT} state_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_data_sync;
  logic                   r_bclk_d, r_lrck_d;
  logic                   w_bclk_rise, w_lr_rise, w_lr_fall, w_data;

  state_t                 r_state;
  logic                   r_chan;      // 0 = left word in progress, 1 = right
  logic                   r_have_left; // a left word of the current frame is stored
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [CW-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]  r_left_word, r_right_word;
  logic                   r_pair_done;
  logic [CW-1:0]          w_pad;
  logic [DATA_WIDTH-1:0]  w_just, w_full;

  // Synchronizers plus one extra flop per control line for edge detection
  always_ff @(posedge s_CLK or posedge s_RESET) begin
    if (s_RESET) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_data_sync <= '0;
      r_bclk_d    <= 1'b0;
      r_lrck_d    <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_BitSCLK};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i_ADC_LRCK};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ADC_Data};
      r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
      r_lrck_d    <= r_lrck_sync[SYNC_STAGES-1];
    end
  end

  assign w_bclk_rise = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_d;
  assign w_lr_rise   = r_lrck_sync[SYNC_STAGES-1] & ~r_lrck_d;
  assign w_lr_fall   = ~r_lrck_sync[SYNC_STAGES-1] & r_lrck_d;
  assign w_data      = r_data_sync[SYNC_STAGES-1];

  // Short word: left-justify the bits taken so far, zero-fill the LSBs
  assign w_pad  = CW'(DATA_WIDTH) - r_cnt;
  assign w_just = r_shift << w_pad;
  assign w_full = {r_shift[DATA_WIDTH-2:0], w_data};

  always_ff @(posedge s_CLK or posedge s_RESET) begin
    if (s_RESET) begin
      r_state      <= S_IDLE;
      r_chan       <= 1'b0;
      r_have_left  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_left_word  <= '0;
      r_right_word <= '0;
      r_pair_done  <= 1'b0;
    end else begin
      r_pair_done <= 1'b0;
      if (!s_EN) begin
        r_state     <= S_IDLE;
        r_have_left <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_lr_fall) begin
              r_state     <= S_DELAY;
              r_chan      <= 1'b0;
              r_have_left <= 1'b0;
            end
          end
          S_DELAY: begin
            if (w_lr_rise || w_lr_fall) begin
              // Restart on the new channel; any stored left no longer pairs
              r_chan      <= w_lr_rise;
              r_have_left <= 1'b0;
            end else if (w_bclk_rise) begin
              r_state <= S_SHIFT;
              r_cnt   <= '0;
              r_shift <= '0;
            end
          end
          S_SHIFT, S_WAIT: begin
            if (w_lr_rise || w_lr_fall) begin
              r_state <= S_DELAY;
              r_chan  <= w_lr_rise;
              if (w_lr_rise && !r_chan) begin
                if (r_state == S_SHIFT) begin
                  r_left_word <= w_just;
                  r_have_left <= 1'b1;
                end
              end else if (w_lr_fall && r_chan && r_state == S_SHIFT && r_have_left) begin
                r_right_word <= w_just;
                r_pair_done  <= 1'b1;
                r_have_left  <= 1'b0;
              end else if (!(w_lr_rise && !r_chan) && !(w_lr_fall && r_chan)) begin
                // Edge that does not end the current channel breaks the frame
                r_have_left <= 1'b0;
              end
            end else if (r_state == S_SHIFT && w_bclk_rise) begin
              r_shift <= w_full;
              r_cnt   <= r_cnt + 1'b1;
              if (r_cnt == CW'(DATA_WIDTH - 1)) begin
                r_state <= S_WAIT;
                if (!r_chan) begin
                  r_left_word <= w_full;
                  r_have_left <= 1'b1;
                end else if (r_have_left) begin
                  r_right_word <= w_full;
                  r_pair_done  <= 1'b1;
                  r_have_left  <= 1'b0;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Output holding stage with overrun detection
  always_ff @(posedge s_CLK or posedge s_RESET) begin
    if (s_RESET) begin
      o_Left    <= '0;
      o_Right   <= '0;
      o_Valid   <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      if (r_pair_done && (!o_Valid || i_Ready)) begin
        o_Left  <= r_left_word;
        o_Right <= r_right_word;
        o_Valid <= 1'b1;
      end else if (o_Valid && i_Ready) begin
        o_Valid <= 1'b0;
      end
      // A same-cycle drop wins over the clear pulse
      if (r_pair_done && o_Valid && !i_Ready)
        o_Overrun <= 1'b1;
      else if (i_OverrunClr)
        o_Overrun <= 1'b0;
    end
  end

  assign o_Busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_audio_adc_i2s_receiver.sv
module tb_audio_adc_i2s_receiver;

  logic        s_CLK = 1'b0;
  logic        s_RESET, s_EN;
  logic        i_BitSCLK, i_ADC_LRCK, i_ADC_Data;
  logic [15:0] o_Left, o_Right;
  logic        i_Ready, o_Valid, o_Overrun, i_OverrunClr, o_Busy;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_l, exp_r;

  always #5 s_CLK = ~s_CLK;

  audio_adc_i2s_receiver #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .s_CLK(s_CLK), .s_RESET(s_RESET), .s_EN(s_EN),
    .i_BitSCLK(i_BitSCLK), .i_ADC_LRCK(i_ADC_LRCK), .i_ADC_Data(i_ADC_Data),
    .o_Left(o_Left), .o_Right(o_Right), .i_Ready(i_Ready), .o_Valid(o_Valid),
    .o_Overrun(o_Overrun), .i_OverrunClr(i_OverrunClr), .o_Busy(o_Busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One BCLK period (8 s_CLK), entered and left on a negedge.
  // mode 1: latency check around the rising edge; mode 2: i_Ready pulse on the load cycle.
  task automatic bclk_cycle(input logic lr, input logic d, input int mode);
    i_BitSCLK = 1'b0; i_ADC_LRCK = lr; i_ADC_Data = d;
    repeat (4) @(negedge s_CLK);
    i_BitSCLK = 1'b1;
    repeat (3) @(negedge s_CLK);
    if (mode == 1) chk("lat_pre_valid", o_Valid, 0);
    if (mode == 2) i_Ready = 1'b1;
    @(negedge s_CLK);
    if (mode == 1) begin
      chk("lat_valid", o_Valid, 1);
      chk("lat_left", o_Left, exp_l);
      chk("lat_right", o_Right, exp_r);
    end
    if (mode == 2) i_Ready = 1'b0;
  endtask

  // Slot 0 is the I2S delay slot, slots 1..nbits carry MSB first, rest pad with 0
  task automatic send_channel(input logic lr, input logic [15:0] w, input int nbits,
                              input int slots, input int lastmode);
    for (int s = 0; s < slots; s++) begin
      logic d;
      d = (s >= 1 && s <= nbits) ? w[nbits - s] : 1'b0;
      bclk_cycle(lr, d, (s == nbits) ? lastmode : 0);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits,
                            input int slots, input int mode);
    send_channel(1'b0, l, nbits, slots, 0);
    send_channel(1'b1, r, nbits, slots, mode);
  endtask

  task automatic idle(input logic lr, input int n);
    for (int k = 0; k < n; k++) bclk_cycle(lr, 1'b0, 0);
  endtask

  task automatic consume();
    i_Ready = 1'b1;
    @(negedge s_CLK);
    i_Ready = 1'b0;
    @(negedge s_CLK);
    chk("consume_valid", o_Valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_RESET = 1'b1; s_EN = 1'b1; i_BitSCLK = 1'b0; i_ADC_LRCK = 1'b1; i_ADC_Data = 1'b0;
    i_Ready = 1'b0; i_OverrunClr = 1'b0;
    repeat (3) @(negedge s_CLK);
    chk("rst_left", o_Left, 0);
    chk("rst_right", o_Right, 0);
    chk("rst_valid", o_Valid, 0);
    chk("rst_ovr", o_Overrun, 0);
    chk("rst_busy", o_Busy, 0);
    s_RESET = 1'b0;
    idle(1'b1, 2);

    // Test 1: reset mid-run clears everything, then a clean frame
    send_frame(16'h1111, 16'h2222, 16, 32, 0);
    send_frame(16'h3333, 16'h4444, 16, 32, 0);
    chk("t1_pre_ovr", o_Overrun, 1);
    #2 s_RESET = 1'b1;
    #1;
    chk("t1_async_valid", o_Valid, 0);
    chk("t1_async_left", o_Left, 0);
    chk("t1_async_ovr", o_Overrun, 0);
    chk("t1_async_busy", o_Busy, 0);
    @(negedge s_CLK);
    s_RESET = 1'b0;
    idle(1'b1, 2);
    send_frame(16'h0F0F, 16'hF0F0, 16, 32, 0);
    chk("t1_valid", o_Valid, 1);
    chk("t1_left", o_Left, 16'h0F0F);
    chk("t1_right", o_Right, 16'hF0F0);
    chk("t1_ovr", o_Overrun, 0);
    consume();

    // Test 2: latency and one-cycle valid pulse with i_Ready held high
    exp_l = 16'hA5C3; exp_r = 16'h1234;
    i_Ready = 1'b1;
    send_frame(16'hA5C3, 16'h1234, 16, 32, 1);
    chk("t2_valid_after", o_Valid, 0);
    chk("t2_ovr", o_Overrun, 0);
    i_Ready = 1'b0;

    // Test 3: two frames without ready -> hold first, flag overrun, then clear
    send_frame(16'h1111, 16'h2222, 16, 32, 0);
    send_frame(16'h3333, 16'h4444, 16, 32, 0);
    chk("t3_valid", o_Valid, 1);
    chk("t3_left", o_Left, 16'h1111);
    chk("t3_right", o_Right, 16'h2222);
    chk("t3_ovr", o_Overrun, 1);
    i_OverrunClr = 1'b1;
    @(negedge s_CLK);
    i_OverrunClr = 1'b0;
    @(negedge s_CLK);
    chk("t3_ovr_clr", o_Overrun, 0);
    chk("t3_hold_left", o_Left, 16'h1111);
    consume();

    // Test 4: ready pulse on the exact load cycle replaces the pair, no overrun
    send_frame(16'h5555, 16'h6666, 16, 32, 0);
    chk("t4_first_left", o_Left, 16'h5555);
    send_frame(16'h7777, 16'h8888, 16, 32, 2);
    chk("t4_valid", o_Valid, 1);
    chk("t4_left", o_Left, 16'h7777);
    chk("t4_right", o_Right, 16'h8888);
    chk("t4_ovr", o_Overrun, 0);
    chk("t4_busy", o_Busy, 1);
    consume();

    // Test 5: enable raised during a right word; that frame never appears
    s_EN = 1'b0;
    repeat (2) @(negedge s_CLK);
    chk("t5_busy_off", o_Busy, 0);
    send_channel(1'b0, 16'h9999, 16, 32, 0);
    i_BitSCLK = 1'b0; i_ADC_LRCK = 1'b1;
    repeat (2) @(negedge s_CLK);
    s_EN = 1'b1;
    send_channel(1'b1, 16'hAAAA, 16, 32, 0);
    chk("t5_no_valid", o_Valid, 0);
    send_frame(16'hBBBB, 16'hCCCC, 16, 32, 0);
    chk("t5_valid", o_Valid, 1);
    chk("t5_left", o_Left, 16'hBBBB);
    chk("t5_right", o_Right, 16'hCCCC);
    consume();

    // Test 6: 12 data slots per channel -> left-justified short words
    send_frame(16'h0ABC, 16'h0123, 12, 13, 0);
    idle(1'b0, 2);
    chk("t6_valid", o_Valid, 1);
    chk("t6_left", o_Left, 16'hABC0);
    chk("t6_right", o_Right, 16'h1230);
    chk("t6_ovr", o_Overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_adc_i2s_receiver.md
Name: audio_adc_i2s_receiver

Overview:
Receive side of the codec audio interface: deserializes the codec ADC stream (ADCDAT framed by BCLK and ADCLRCK, I2S format) into parallel left/right sample pairs. BCLK and ADCLRCK are driven by the codec or by the codec control block and are asynchronous to s_CLK. Inputs are synchronized, edges are detected, the serial data is shifted in, and each stereo pair is presented on a valid/ready output with overrun detection. Sits beside the DAC/I2C control path and feeds the audio-processing datapath.

Parameters:
DATA_WIDTH, 16, bits captured per channel word (MSB first)
SYNC_STAGES, 2, flip-flop stages on i_BitSCLK, i_ADC_LRCK and i_ADC_Data (minimum 2)

Ports:
s_CLK  input  1  system clock; must be at least 4x the BCLK frequency
s_RESET  input  1  asynchronous, active-high reset
s_EN  input  1  receiver enable
i_BitSCLK  input  1  bit clock (BCLK)
i_ADC_LRCK  input  1  ADC word select: 0 = left, 1 = right
i_ADC_Data  input  1  ADC serial data (ADCDAT)
o_Left  output  DATA_WIDTH  left sample of the presented pair
o_Right  output  DATA_WIDTH  right sample of the presented pair
i_Ready  input  1  consumer accepts the pair when o_Valid and i_Ready are both high
o_Valid  output  1  pair available
o_Overrun  output  1  sticky flag: a completed pair was dropped
i_OverrunClr  input  1  single-cycle pulse that clears o_Overrun
o_Busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: o_Left=0, o_Right=0, o_Valid=0, o_Overrun=0, o_Busy=0, FSM=IDLE, shift register=0, bit counter=0, synchronizers=0.
- Edge detection: synced BCLK 0->1 defines a rise event; synced LRCK 1->0 defines a fall event and 0->1 a rise event. Each event lasts one s_CLK cycle. Data is sampled from synced i_ADC_Data on a BCLK rise event only.
- I2S framing: the MSB arrives on the second BCLK rise after an LRCK transition. The first BCLK rise after the transition is the one-bit delay slot and is skipped.
- FSM:
  - IDLE: wait for an LRCK fall event while s_EN=1, then go to DELAY with channel=left.
  - DELAY: the next BCLK rise is discarded; go to SHIFT with counter=0.
  - SHIFT: on each BCLK rise, shift = {shift[DATA_WIDTH-2:0], data} and increment the counter. When the counter reaches DATA_WIDTH, store the word into the channel holding register and go to WAIT.
  - WAIT: ignore BCLK. An LRCK rise event after a left word switches to the right channel and goes to DELAY. An LRCK fall event after a right word completes the pair and goes to DELAY for the next left word.
  - Short word: if an LRCK transition occurs in SHIFT before DATA_WIDTH bits have been taken, store the partial word left-justified with zero LSBs and treat the transition as in WAIT.
  - LRCK edge in DELAY: restart DELAY on the new channel; the current word is discarded.
- Pair completion: the right word is committed the cycle after its last BCLK rise event. The output registers load on the following cycle. o_Valid rises SYNC_STAGES+2 s_CLK cycles after the pin-level BCLK rising edge that carries the right LSB.
- Handshake:
  - o_Left, o_Right and o_Valid hold until a cycle in which o_Valid and i_Ready are both high. Then o_Valid clears next cycle, unless a new pair loads in that same cycle, in which case o_Valid stays 1 with the new data and no overrun.
  - If a new pair completes while o_Valid=1 and i_Ready=0: the new pair is dropped, the old pair is held, and o_Overrun is set.
  - i_OverrunClr has lower priority than a same-cycle set.
- s_EN low: FSM returns to IDLE next cycle and any partial word or pair is discarded. The output registers, o_Valid and o_Overrun are retained, and a pending pair can still be consumed. After re-enable, the first pair output is the first complete left+right frame after an LRCK fall.
- Only a left word followed by a right word forms a pair. A lone right word seen after enable is never output.

Test Plan:
1. Assert s_RESET mid-run -> all outputs 0 asynchronously. After release, a full frame with L=16'h0F0F, R=16'hF0F0 -> o_Left=16'h0F0F, o_Right=16'hF0F0.
2. BCLK = s_CLK/8, 32 BCLK per frame, L=16'hA5C3, R=16'h1234, i_Ready=1 -> one o_Valid pulse with o_Left=16'hA5C3 and o_Right=16'h1234, SYNC_STAGES+2 cycles after the right LSB BCLK edge. Trailing 0 padding bits are ignored.
3. i_Ready=0 for two frames (L/R 16'h1111/16'h2222, then 16'h3333/16'h4444) -> o_Valid stays 1 holding 16'h1111/16'h2222 and o_Overrun=1. Pulse i_OverrunClr -> o_Overrun=0.
4. i_Ready pulses exactly in the cycle the next pair loads -> o_Valid stays 1 with the new data and o_Overrun stays 0.
5. Raise s_EN during a right-channel word -> that partial frame is discarded and the first output is the next complete frame.
6. 12 BCLK per channel (short word), L bits 12'hABC -> o_Left=16'hABC0.
